hsi_vector_core_engine: RTL
===========================

Name: hsi_vector_core_engine

Overview:
Computational datapath of the HSI vector core, directly downstream of the OBI register wrapper. It consumes the wrapper's start, op_code and pixel_size outputs. It streams pixel_size band-pairs (pixel sample A, reference sample B) through a valid/ready element interface and accumulates a per-pixel metric. It returns result, valid_result, pixel_done and busy to the wrapper's status and result registers.

Parameters:
DATA_W, 16, width of each unsigned band sample
ACC_W, 48, internal accumulator width; must be at least 2*DATA_W+16
RES_W, 16, width of result_o; the accumulator saturates into this width

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle start pulse from the wrapper
op_code_i  in  2  0=DOT (sum a*b), 1=SAD (sum |a-b|), 2=SSD (sum (a-b)^2), 3=illegal
pixel_size_i  in  16  number of band-pairs in the pixel
a_data_i  in  DATA_W  pixel band sample
b_data_i  in  DATA_W  reference band sample
elem_valid_i  in  1  a/b pair is valid this cycle
elem_ready_o  out  1  engine accepts a pair this cycle
result_o  out  RES_W  saturated metric
valid_result_o  out  1  result_o holds the result of the last completed pixel
pixel_done_o  out  1  one-cycle completion pulse
busy_o  out  1  operation in progress

Behaviour:
- Reset values: elem_ready_o=0, result_o=0, valid_result_o=0, pixel_done_o=0, busy_o=0. FSM goes to IDLE, and the accumulator, element counter and stage-1 register clear.
- Reset mid-operation aborts immediately. In-flight data is discarded and no pixel_done_o is generated.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start_i=1, op_code_i in 0..2, pixel_size_i>0:
  - Latch op_code and pixel_size; clear the accumulator and counter.
  - valid_result_o<=0, busy_o<=1, go to RUN.
- IDLE, start_i=1, op_code_i=3 or pixel_size_i=0: go to DONE with accumulator=0. busy_o pulses for one cycle.
- start_i outside IDLE is ignored. The latched op/size are unaffected.
- RUN:
  - elem_ready_o=1 (combinational from state); a transfer occurs when elem_valid_i & elem_ready_o.
  - Stage 1 registers the term and its valid flag:
    - DOT: a*b (2*DATA_W bits).
    - SAD: |a-b| (DATA_W bits).
    - SSD: (a-b)^2 (2*DATA_W bits, unsigned).
  - Stage 2 zero-extends the term and adds it into ACC_W bits in the following cycle.
  - The counter increments per transfer. The transfer with counter==pixel_size-1 moves the FSM to DRAIN.
  - Gaps in elem_valid_i only stall; they have no other effect.
- DRAIN: elem_ready_o=0. The final term is accumulated, then go to DONE.
- DONE:
  - result_o <= (acc > 2^RES_W-1) ? all-ones : acc[RES_W-1:0].
  - valid_result_o<=1, pixel_done_o<=1, busy_o<=0, go to IDLE.
- Latency: last transfer in cycle N, so DRAIN in N+1, DONE in N+2, outputs visible in N+3.
  - pixel_done_o is high only in cycle N+3.
  - result_o and valid_result_o hold until the next accepted start or reset.
- busy_o is registered: high from the cycle after start is accepted through DONE, low in the cycle pixel_done_o is high.
- No accumulator wrap for pixel_size up to 65535 at DATA_W=16; only the output saturates.

Decomposition:
- Package hsi_pkg holds:
  - Op-code enum: OP_DOT=0, OP_SAD=1, OP_SSD=2, OP_ILLEGAL=3.
  - FSM state enum.
  - The 16-bit pixel_size width constant, shared with the wrapper.
- One sub-module, hsi_elem_term: stage-1 term computation plus its register (valid, op, a, b in; term, term_valid out). FSM, counter, accumulator and saturation stay in the top module.

Test Plan:
1. Reset for 2 cycles, then idle -> all outputs 0, elem_ready_o=0, busy_o=0.
2. start op=0 size=4; a={1,2,3,4}, b={5,6,7,8} sent back-to-back -> result_o=70, valid_result_o=1, pixel_done_o high exactly 3 cycles after the 4th transfer, busy_o low in that same cycle.
3. start op=1 size=3; a={10,0,7}, b={3,5,7} with 2 idle cycles between elements -> result_o=12; start_i pulsed mid-RUN is ignored (result still 12, no restart).
4. start op=2 size=2; a={300,0}, b={0,300} -> accumulator 180000, result_o=0xFFFF (saturated).
5. start op=3 size=8, then start op=0 size=0 -> each gives one pixel_done_o pulse 2 cycles after start, result_o=0, elem_ready_o never high.
6. Assert rst_i during RUN after 2 of 4 elements, then rerun scenario 2 -> outputs 0 during reset, no pixel_done_o from the aborted run, rerun gives 70.

Source files
------------

// File: rtl/hsi_pkg.sv
// ---------------------------------------------------------------------------
// hsi_pkg
// Shared types and constants for the HSI vector core.
//   op_e          : metric selector driven by the register wrapper
//   state_e       : engine control FSM states
//   PIXEL_SIZE_W  : width of the pixel_size field (shared with the wrapper)
//   is_legal_start: true when a start request describes a runnable pixel
// ---------------------------------------------------------------------------
package hsi_pkg;

    localparam int PIXEL_SIZE_W = 16;

    typedef enum logic [1:0] {
        OP_DOT     = 2'd0,
        OP_SAD     = 2'd1,
        OP_SSD     = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // An illegal op or an empty pixel skips straight to completion.
    function automatic logic is_legal_start(input logic [1:0]              op,
                                            input logic [PIXEL_SIZE_W-1:0] size);
        return (op_e'(op) != OP_ILLEGAL) && (size != '0);
    endfunction

endpackage

// File: rtl/hsi_elem_term.sv
// ---------------------------------------------------------------------------
// hsi_elem_term
// Stage 1 of the engine datapath: computes the per-band term for the
// selected metric and registers it together with a valid flag.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   valid_i       : an a/b pair is transferred this cycle
//   op_i          : metric (DOT / SAD / SSD)
//   a_i, b_i      : unsigned band samples
//   term_o        : registered term, 2*DATA_W bits, zero-extended for SAD
//   term_valid_o  : term_o carries a fresh term this cycle
// ---------------------------------------------------------------------------
module hsi_elem_term
    import hsi_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  op_e                   op_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic [2*DATA_W-1:0]   term_o,
    output logic                  term_valid_o
);

    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] term_d;
    logic [2*DATA_W-1:0] term_q;
    logic                term_valid_q;

    always_comb begin
        // Absolute difference keeps SAD/SSD purely unsigned.
        diff   = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        term_d = '0;
        case (op_i)
            OP_DOT:  term_d = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
            OP_SAD:  term_d = {{DATA_W{1'b0}}, diff};
            OP_SSD:  term_d = {{DATA_W{1'b0}}, diff} * {{DATA_W{1'b0}}, diff};
            default: term_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            term_q       <= '0;
            term_valid_q <= 1'b0;
        end else begin
            term_valid_q <= valid_i;
            if (valid_i) begin
                term_q <= term_d;
            end
        end
    end

    assign term_o       = term_q;
    assign term_valid_o = term_valid_q;

endmodule

// File: rtl/hsi_vector_core_engine.sv
// ---------------------------------------------------------------------------
// hsi_vector_core_engine
// Streams pixel_size band-pairs through a valid/ready interface and
// accumulates DOT, SAD or SSD; the final sum saturates into RES_W bits.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   start_i         : one-cycle start pulse (honoured only in IDLE)
//   op_code_i       : 0=DOT 1=SAD 2=SSD 3=illegal
//   pixel_size_i    : number of band-pairs in the pixel
//   a_data_i/b_data_i, elem_valid_i, elem_ready_o : element stream
//   result_o        : saturated metric of the last completed pixel
//   valid_result_o  : result_o is valid
//   pixel_done_o    : one-cycle completion pulse
//   busy_o          : operation in progress
// Pipeline: transfer (N) -> stage-1 term reg -> accumulate in DRAIN (N+1)
// -> saturate in DONE (N+2) -> outputs visible in N+3.
// ---------------------------------------------------------------------------
module hsi_vector_core_engine
    import hsi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int RES_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [1:0]              op_code_i,
    input  logic [PIXEL_SIZE_W-1:0] pixel_size_i,
    input  logic [DATA_W-1:0]       a_data_i,
    input  logic [DATA_W-1:0]       b_data_i,
    input  logic                    elem_valid_i,
    output logic                    elem_ready_o,
    output logic [RES_W-1:0]        result_o,
    output logic                    valid_result_o,
    output logic                    pixel_done_o,
    output logic                    busy_o
);

    state_e                  state_q, state_d;
    op_e                     op_q;
    logic [PIXEL_SIZE_W-1:0] size_q;
    logic [PIXEL_SIZE_W-1:0] cnt_q;
    logic [ACC_W-1:0]        acc_q;
    logic [RES_W-1:0]        result_q;
    logic                    valid_result_q;
    logic                    pixel_done_q;
    logic                    busy_q;

    logic                    elem_ready;
    logic                    transfer;
    logic                    start_legal;
    logic                    last_elem;
    logic [2*DATA_W-1:0]     term;
    logic                    term_valid;

    assign start_legal = is_legal_start(op_code_i, pixel_size_i);
    assign transfer    = elem_valid_i & elem_ready;
    // size_q is never zero in RUN, so size_q-1 cannot underflow there.
    assign last_elem   = (cnt_q == (size_q - PIXEL_SIZE_W'(1)));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        elem_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = start_legal ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                elem_ready = 1'b1;
                if (transfer && last_elem) begin
                    state_d = ST_DRAIN;
                end
            end
            // The last term is sitting in the stage-1 register; give it
            // one cycle to reach the accumulator.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: term computation
    // ------------------------------------------------------------------
    hsi_elem_term #(
        .DATA_W (DATA_W)
    ) u_elem_term (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (transfer),
        .op_i         (op_q),
        .a_i          (a_data_i),
        .b_i          (b_data_i),
        .term_o       (term),
        .term_valid_o (term_valid)
    );

    // ------------------------------------------------------------------
    // Stage 2 accumulate, counter, saturation and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q           <= OP_DOT;
            size_q         <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            valid_result_q <= 1'b0;
            pixel_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            pixel_done_q <= 1'b0;

            if ((state_q == ST_IDLE) && start_i) begin
                acc_q          <= '0;
                cnt_q          <= '0;
                valid_result_q <= 1'b0;
                busy_q         <= 1'b1;
                if (start_legal) begin
                    op_q   <= op_e'(op_code_i);
                    size_q <= pixel_size_i;
                end
            end else if (term_valid) begin
                acc_q <= acc_q + {{(ACC_W-2*DATA_W){1'b0}}, term};
            end

            if (transfer) begin
                cnt_q <= cnt_q + PIXEL_SIZE_W'(1);
            end

            if (state_q == ST_DONE) begin
                if (|acc_q[ACC_W-1:RES_W]) begin
                    result_q <= '1;
                end else begin
                    result_q <= acc_q[RES_W-1:0];
                end
                valid_result_q <= 1'b1;
                pixel_done_q   <= 1'b1;
                busy_q         <= 1'b0;
            end
        end
    end

    assign elem_ready_o   = elem_ready;
    assign result_o       = result_q;
    assign valid_result_o = valid_result_q;
    assign pixel_done_o   = pixel_done_q;
    assign busy_o         = busy_q;

endmodule
